// File: rtl/eth_rx_fcs_check.sv
// GMII receive FCS checker: strips preamble/SFD, runs CRC32 over the frame,
// forwards payload with the 4 FCS bytes removed and emits one end-of-frame status pulse.
`timescale 1ns/1ps
module eth_rx_fcs_check #(
   parameter int MAX_LEN = 1518,
   parameter int MIN_LEN = 64,
   parameter int MAX_PRE = 7
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic [7:0]  rxd,
   output logic        out_valid,
   output logic        out_sof,
   output logic [7:0]  out_data,
   output logic        stat_valid,
   output logic        stat_good,
   output logic        stat_crc_err,
   output logic        stat_rx_err,
   output logic        stat_runt,
   output logic        stat_long,
   output logic [15:0] stat_len
);

   localparam int             PW        = $clog2(MAX_PRE + 1);
   localparam logic [PW-1:0]  MAX_PRE_C = PW'(MAX_PRE);
   localparam logic [15:0]    MIN_LEN_C = 16'(MIN_LEN);
   localparam logic [15:0]    MAX_LEN_C = 16'(MAX_LEN);
   localparam logic [7:0]     PRE_BYTE  = 8'h55;
   localparam logic [7:0]     SFD_BYTE  = 8'hD5;
   localparam logic [31:0]    POLY      = 32'h04C1_1DB7;
   localparam logic [31:0]    RESIDUE   = 32'hC704_DD7B;

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

   typedef struct packed {
      logic        good;
      logic        crc_err;
      logic        rx_err;
      logic        runt;
      logic        too_long;
      logic [15:0] len;
   } stat_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
   logic [31:0]     crc_q, crc_d;
   logic [15:0]     len_q, len_d;
   logic            rx_err_q, rx_err_d;
   logic [3:0][7:0] dl_q, dl_d;
   logic            out_valid_q, out_valid_d;
   logic            out_sof_q, out_sof_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            stat_valid_q, stat_valid_d;
   stat_t           stat_q, stat_d;

   // MSB-first register; rxd[0] enters first, which is the bit reversal of the byte.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
      return c;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d      = state_q;
      pre_cnt_d    = pre_cnt_q;
      crc_d        = crc_q;
      len_d        = len_q;
      rx_err_d     = rx_err_q;
      dl_d         = dl_q;
      out_valid_d  = 1'b0;
      out_sof_d    = 1'b0;
      out_data_d   = out_data_q;
      stat_valid_d = 1'b0;
      stat_d       = stat_q;

      unique case (state_q)
         S_IDLE: begin
            if (rx_dv) begin
               if (rxd == PRE_BYTE) begin
                  state_d   = S_PRE;
                  pre_cnt_d = PW'(1);
               end else begin
                  state_d = S_DROP;
               end
            end
         end
         S_PRE: begin
            if (!rx_dv) begin
               state_d = S_IDLE;
            end else if (rxd == PRE_BYTE && pre_cnt_q < MAX_PRE_C) begin
               pre_cnt_d = pre_cnt_q + PW'(1);
            end else if (rxd == SFD_BYTE) begin
               state_d  = S_DATA;
               crc_d    = '1;
               len_d    = '0;
               rx_err_d = 1'b0;
               dl_d     = '0;
            end else begin
               state_d = S_DROP;
            end
         end
         S_DATA: begin
            if (rx_dv) begin
               dl_d  = {dl_q[2:0], rxd};
               crc_d = crc32_byte(crc_q, rxd);
               len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
               if (rx_er) rx_err_d = 1'b1;
               // The delay line is full from the fifth byte on; each new byte evicts the oldest.
               if (len_q >= 16'd4) begin
                  out_valid_d = 1'b1;
                  out_sof_d   = (len_q == 16'd4);
                  out_data_d  = dl_q[3];
               end
            end else begin
               state_d         = S_IDLE;
               stat_valid_d    = 1'b1;
               stat_d.crc_err  = (crc_q != RESIDUE);
               stat_d.rx_err   = rx_err_q;
               stat_d.runt     = (len_q < MIN_LEN_C);
               stat_d.too_long = (len_q > MAX_LEN_C);
               stat_d.len      = len_q;
               stat_d.good     = !((crc_q != RESIDUE) || rx_err_q ||
                                   (len_q < MIN_LEN_C) || (len_q > MAX_LEN_C));
            end
         end
         S_DROP: begin
            if (!rx_dv) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         pre_cnt_q    <= '0;
         crc_q        <= '1;
         len_q        <= '0;
         rx_err_q     <= 1'b0;
         // NOTE: the 4-byte delay line is small enough to reset, so no stale FCS can leak out.
         dl_q         <= '0;
         out_valid_q  <= 1'b0;
         out_sof_q    <= 1'b0;
         out_data_q   <= '0;
         stat_valid_q <= 1'b0;
         stat_q       <= '0;
      end else begin
         state_q      <= state_d;
         pre_cnt_q    <= pre_cnt_d;
         crc_q        <= crc_d;
         len_q        <= len_d;
         rx_err_q     <= rx_err_d;
         dl_q         <= dl_d;
         out_valid_q  <= out_valid_d;
         out_sof_q    <= out_sof_d;
         out_data_q   <= out_data_d;
         stat_valid_q <= stat_valid_d;
         stat_q       <= stat_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_sof      = out_sof_q;
   assign out_data     = out_data_q;
   assign stat_valid   = stat_valid_q;
   assign stat_good    = stat_q.good;
   assign stat_crc_err = stat_q.crc_err;
   assign stat_rx_err  = stat_q.rx_err;
   assign stat_runt    = stat_q.runt;
   assign stat_long    = stat_q.too_long;
   assign stat_len     = stat_q.len;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: frames are built with a reflected CRC32 model,
// expected beats/status are queued as stimulus is driven and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_eth_rx_fcs_check;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        rx_dv;
   logic        rx_er;
   logic [7:0]  rxd;
   logic        out_valid, out_sof, stat_valid, stat_good;
   logic        stat_crc_err, stat_rx_err, stat_runt, stat_long;
   logic [7:0]  out_data;
   logic [15:0] stat_len;

   eth_rx_fcs_check dut (
      .Clk(Clk), .Reset(Reset), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
      .out_valid(out_valid), .out_sof(out_sof), .out_data(out_data),
      .stat_valid(stat_valid), .stat_good(stat_good), .stat_crc_err(stat_crc_err),
      .stat_rx_err(stat_rx_err), .stat_runt(stat_runt), .stat_long(stat_long),
      .stat_len(stat_len)
   );

   always #4 Clk = ~Clk;

   typedef struct packed {
      logic       sof;
      logic [7:0] data;
   } beat_t;

   typedef struct packed {
      logic        good;
      logic        crc_err;
      logic        rx_err;
      logic        runt;
      logic        too_long;
      logic [15:0] len;
   } stat_t;

   beat_t      exp_beats[$];
   stat_t      exp_stats[$];
   logic [7:0] frm[$];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Standard reflected CRC32 (poly 0xEDB88320) over the current frame buffer, no final invert.
   function automatic logic [31:0] frm_crc();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < frm.size(); i++) begin
         c = c ^ {24'h0, frm[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   task automatic build_frame(input int n_payload, input logic [7:0] seed);
      logic [31:0] fcs;
      frm.delete();
      for (int i = 0; i < n_payload; i++) frm.push_back(8'(i) + seed);
      fcs = ~frm_crc();
      for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      @(negedge Clk);
      rx_dv = dv;
      rx_er = er;
      rxd   = d;
   endtask

   task automatic send_preamble();
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
   endtask

   // Drives bytes [0, n) of frm, queueing each payload byte evicted from the 4-byte delay.
   task automatic send_bytes(input int n, input int er_idx);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         if (i >= 4) begin
            b.sof  = (i == 4);
            b.data = frm[i-4];
            exp_beats.push_back(b);
         end
         drive(1'b1, (i == er_idx), frm[i]);
      end
   endtask

   task automatic send_frame(input int er_idx);
      stat_t s;
      int    n;
      n = frm.size();
      send_preamble();
      send_bytes(n, er_idx);
      s.len      = (n > 65535) ? 16'hFFFF : 16'(n);
      s.crc_err  = (frm_crc() != 32'hDEBB_20E3);
      s.rx_err   = (er_idx >= 0 && er_idx < n);
      s.runt     = (n < 64);
      s.too_long = (n > 1518);
      s.good     = !(s.crc_err || s.rx_err || s.runt || s.too_long);
      exp_stats.push_back(s);
      drive(1'b0, 1'b0, 8'h00);
   endtask

   function automatic logic [31:0] all_outputs();
      return {out_valid, out_sof, out_data, stat_valid, stat_good, stat_crc_err,
              stat_rx_err, stat_runt, stat_long, stat_len};
   endfunction

   beat_t mon_b;
   stat_t mon_s;

   always @(negedge Clk) begin
      if (!Reset) begin
         if (out_valid) begin
            if (exp_beats.size() == 0) begin
               check("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
               mon_b = exp_beats.pop_front();
               check("beat_data", 32'(out_data), 32'(mon_b.data));
               check("beat_sof", 32'(out_sof), 32'(mon_b.sof));
            end
         end else if (out_sof) begin
            check("sof_without_valid", 32'(out_sof), 32'd0);
         end
         if (stat_valid) begin
            if (exp_stats.size() == 0) begin
               check("unexpected_stat", 32'(stat_valid), 32'd0);
            end else begin
               mon_s = exp_stats.pop_front();
               check("payload_drained", 32'(exp_beats.size()), 32'd0);
               check("stat_good", 32'(stat_good), 32'(mon_s.good));
               check("stat_crc_err", 32'(stat_crc_err), 32'(mon_s.crc_err));
               check("stat_rx_err", 32'(stat_rx_err), 32'(mon_s.rx_err));
               check("stat_runt", 32'(stat_runt), 32'(mon_s.runt));
               check("stat_long", 32'(stat_long), 32'(mon_s.too_long));
               check("stat_len", 32'(stat_len), 32'(mon_s.len));
            end
         end
      end
   end

   initial begin
      Reset = 1'b1;
      rx_dv = 1'b0;
      rx_er = 1'b0;
      rxd   = 8'h00;
      #1;
      check("reset_outputs", all_outputs(), 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      drive(1'b0, 1'b0, 8'h00);

      // Good 64-byte frame, payload 0x00..0x3B.
      build_frame(60, 8'h00);
      send_frame(-1);

      // Same frame with bit 0 of payload byte 10 flipped.
      build_frame(60, 8'h00);
      frm[10] = frm[10] ^ 8'h01;
      send_frame(-1);

      // 100-byte frame with rx_er on payload byte 20.
      build_frame(96, 8'h20);
      send_frame(20);

      // Broken preamble then 70 bytes: silently dropped.
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'(i * 3));
      drive(1'b0, 1'b0, 8'h00);
      build_frame(60, 8'h05);
      send_frame(-1);

      // Length boundaries: 1519 (long), 63 (runt), 3 bytes (runt + crc error, no payload).
      build_frame(1515, 8'h40);
      send_frame(-1);
      build_frame(59, 8'h77);
      send_frame(-1);
      frm.delete();
      frm.push_back(8'h11);
      frm.push_back(8'h22);
      frm.push_back(8'h33);
      send_frame(-1);

      // Reset mid-payload after byte 30 is accepted.
      build_frame(60, 8'h00);
      send_preamble();
      send_bytes(30, -1);
      @(negedge Clk);
      #1;
      Reset = 1'b1;
      rx_dv = 1'b0;
      rxd   = 8'h00;
      #1;
      check("reset_midframe_outputs", all_outputs(), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      build_frame(60, 8'h09);
      send_frame(-1);

      repeat (4) @(negedge Clk);
      check("beats_left", 32'(exp_beats.size()), 32'd0);
      check("stats_left", 32'(exp_stats.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
